ik_swift_hps_master_0_b2p_adapter: RTL and testbench
====================================================

// Module: ik_swift_hps_master_0_b2p_adapter
// PURPOSE
//  Receive-side channel adapter: inverse of the packet-to-byte channel mapper.
//  Takes a channelised Avalon-ST packet stream and strips the channel field.
//  Forwards whole packets whose channel equals ACCEPT_CHANNEL and discards all others.
//  Sits between the byte-to-packet converter and the master's packet consumer.
//  Registered skid-buffered output breaks the ready/valid timing path.
// PARAMETERS
//  DATA_W          8   payload width (bits)
//  CHANNEL_W       8   width of in_channel
//  ACCEPT_CHANNEL  0   channel number that is forwarded
//  CNT_W           16  width of drop_count
// PORTS
//  clk                in   1          single clock, all logic rising-edge
//  reset              in   1          synchronous, active-high reset
//  in_ready           out  1          sink ready (registered)
//  in_valid           in   1          sink beat valid
//  in_data            in   DATA_W     sink payload
//  in_channel         in   CHANNEL_W  sink channel; sampled on SOP beats only
//  in_startofpacket   in   1          first beat of packet
//  in_endofpacket     in   1          last beat of packet
//  out_ready          in   1          source ready
//  out_valid          out  1          source beat valid (registered)
//  out_data           out  DATA_W     source payload
//  out_startofpacket  out  1          forwarded SOP
//  out_endofpacket    out  1          forwarded EOP
//  drop_count         out  CNT_W      number of packets discarded, saturating
//  protocol_err       out  1          sticky framing-error flag
// BEHAVIOUR
//  - Beat accepted when in_valid & in_ready. Source transfer when out_valid & out_ready.
//  - Reset values: in_ready=1, out_valid=0, out_data=0, out_sop=0, out_eop=0,
//    drop_count=0, protocol_err=0, FSM=IDLE, skid buffer empty.
//  - FSM:
//    - IDLE: accepted beat with SOP and channel==ACCEPT_CHANNEL -> PASS, unless EOP.
//    - IDLE: accepted beat with SOP and channel!=ACCEPT_CHANNEL -> DROP, unless EOP.
//    - IDLE: accepted beat without SOP -> orphan; discard it, set protocol_err, stay IDLE.
//    - PASS: each beat is forwarded. The EOP beat -> IDLE.
//    - DROP: each beat is discarded. The EOP beat -> IDLE.
//    - drop_count increments on the SOP beat of every discarded packet.
//  - Single-beat packet (SOP & EOP): same decision as above; FSM remains IDLE.
//  - SOP while in PASS or DROP (missing EOP):
//    - set protocol_err;
//    - re-decide on the new channel and enter the resulting state;
//    - the previous forwarded packet is not closed, i.e. no EOP is synthesised.
//  - Forward path is a 2-entry skid buffer (output register + skid register):
//    - latency: 1 cycle from accepted beat to out_valid;
//    - full throughput of 1 beat/clk while out_ready=1;
//    - in_ready = !skid_full, registered;
//    - out_* held stable while out_valid & !out_ready;
//    - no beat is lost or duplicated.
//  - Discarded beats never occupy the buffer. They are consumed whenever in_ready=1.
//  - drop_count saturates at all-ones. protocol_err clears only on reset.
//  - Reset mid-packet: buffer flushed, FSM=IDLE.
//    - Next beat must carry SOP; otherwise it is an orphan.
// CONFIGURATION
//  - B2P_CHANNEL_FILTER_EN defined:
//    - filtering as above; in_channel compared against ACCEPT_CHANNEL.
//  - B2P_CHANNEL_FILTER_EN undefined:
//    - every packet is treated as ACCEPT_CHANNEL and forwarded;
//    - DROP state is unreachable;
//    - drop_count tied to 0;
//    - in_channel ignored;
//    - framing checks and protocol_err unchanged.
// TESTING
//  - Pass packet:
//    - stimulus: 4 beats, ch=0, data 0x11..0x44, out_ready=1;
//    - required: out 0x11..0x44 back-to-back, SOP on 0x11, EOP on 0x44;
//      first out_valid 1 clk after the first accept; drop_count=0.
//  - Drop packet:
//    - stimulus: 3 beats, ch=5, then a 2-beat ch=0 packet;
//    - required: only the ch=0 beats appear at the output;
//      drop_count=1; in_ready stays 1 during ch=5.
//  - Backpressure:
//    - stimulus: 8-beat ch=0 packet; out_ready toggled 1,0,0,1...;
//    - required: all 8 bytes delivered in order, none repeated;
//      in_ready low only when the skid register is full.
//  - Single-beat:
//    - stimulus: SOP&EOP, ch=0, data 0xA5, then SOP&EOP, ch=7;
//    - required: one output beat 0xA5 with SOP=EOP=1; drop_count=1.
//  - Framing:
//    - stimulus: beat without SOP in IDLE -> required: discarded, protocol_err=1;
//    - stimulus: SOP mid-PASS -> required: new packet forwarded from its SOP.
//  - Reset mid-packet:
//    - stimulus: assert reset after beat 2 of 4 (ch=0); next packet starts with SOP;
//    - required: out_valid=0 during reset; new packet output intact;
//      counters cleared.
//  - Macro off:
//    - stimulus: ch=5 packet;
//    - required: packet forwarded; drop_count=0.

Source files
------------

// File: rtl/ik_swift_hps_master_0_b2p_adapter.sv
// Receive-side channel adapter: strips the channel field and forwards whole packets on ACCEPT_CHANNEL.
// Optional channel filtering is enabled by defining B2P_CHANNEL_FILTER_EN; otherwise every packet is forwarded.
module ik_swift_hps_master_0_b2p_adapter #(
   parameter int DATA_W         = 8,
   parameter int CHANNEL_W      = 8,
   parameter int ACCEPT_CHANNEL = 0,
   parameter int CNT_W          = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   output logic                 in_ready,
   input  logic                 in_valid,
   input  logic [DATA_W-1:0]    in_data,
   input  logic [CHANNEL_W-1:0] in_channel,
   input  logic                 in_startofpacket,
   input  logic                 in_endofpacket,
   input  logic                 out_ready,
   output logic                 out_valid,
   output logic [DATA_W-1:0]    out_data,
   output logic                 out_startofpacket,
   output logic                 out_endofpacket,
   output logic [CNT_W-1:0]     drop_count,
   output logic                 protocol_err
);

   localparam logic [CHANNEL_W-1:0] ACC_CH = CHANNEL_W'(ACCEPT_CHANNEL);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PASS = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t              state_r;
   state_t              state_nxt_s;
   logic                ch_match_s;
   logic                pass_pkt_s;
   logic                accept_s;
   logic                fwd_s;
   logic                drop_inc_s;
   logic                err_set_s;
   logic                pop_s;
   logic                skid_valid_r;
   logic [DATA_W-1:0]   skid_data_r;
   logic                skid_sop_r;
   logic                skid_eop_r;

   // Packet framing decision: which accepted beats are forwarded and how the FSM moves.
   always_comb begin
      ch_match_s  = (in_channel == ACC_CH);
`ifdef B2P_CHANNEL_FILTER_EN
      pass_pkt_s  = ch_match_s;
`else
      // Channel is ignored; the compare stays so both builds share one datapath.
      pass_pkt_s  = 1'b1 | ch_match_s;
`endif
      accept_s    = in_valid & in_ready;
      fwd_s       = 1'b0;
      drop_inc_s  = 1'b0;
      err_set_s   = 1'b0;
      state_nxt_s = state_r;
      if (accept_s) begin
         if (in_startofpacket) begin
            fwd_s      = pass_pkt_s;
            drop_inc_s = ~pass_pkt_s;
            err_set_s  = (state_r != IDLE);
            if (in_endofpacket) begin
               state_nxt_s = IDLE;
            end else if (pass_pkt_s) begin
               state_nxt_s = PASS;
            end else begin
               state_nxt_s = DROP;
            end
         end else begin
            case (state_r)
               IDLE: begin
                  err_set_s   = 1'b1;
                  state_nxt_s = IDLE;
               end
               PASS: begin
                  fwd_s       = 1'b1;
                  state_nxt_s = in_endofpacket ? IDLE : PASS;
               end
               DROP: begin
                  state_nxt_s = in_endofpacket ? IDLE : DROP;
               end
               default: begin
                  state_nxt_s = IDLE;
               end
            endcase
         end
      end else begin
         state_nxt_s = state_r;
      end
   end

   assign pop_s = out_valid & out_ready;

   // FSM, skid buffer, drop counter and sticky error flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r           <= IDLE;
         in_ready          <= 1'b1;
         out_valid         <= 1'b0;
         out_data          <= {DATA_W{1'b0}};
         out_startofpacket <= 1'b0;
         out_endofpacket   <= 1'b0;
         skid_valid_r      <= 1'b0;
         skid_data_r       <= {DATA_W{1'b0}};
         skid_sop_r        <= 1'b0;
         skid_eop_r        <= 1'b0;
         drop_count        <= {CNT_W{1'b0}};
         protocol_err      <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         if (!out_valid || pop_s) begin
            // Output register is free this cycle: refill from skid first to keep order.
            if (skid_valid_r) begin
               out_valid         <= 1'b1;
               out_data          <= skid_data_r;
               out_startofpacket <= skid_sop_r;
               out_endofpacket   <= skid_eop_r;
               skid_valid_r      <= fwd_s;
               in_ready          <= ~fwd_s;
               if (fwd_s) begin
                  skid_data_r <= in_data;
                  skid_sop_r  <= in_startofpacket;
                  skid_eop_r  <= in_endofpacket;
               end else begin
                  skid_data_r <= skid_data_r;
               end
            end else if (fwd_s) begin
               out_valid         <= 1'b1;
               out_data          <= in_data;
               out_startofpacket <= in_startofpacket;
               out_endofpacket   <= in_endofpacket;
               in_ready          <= 1'b1;
            end else begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         end else begin
            // Output stalled; a forwarded beat can only arrive while skid is empty.
            if (fwd_s) begin
               skid_valid_r <= 1'b1;
               skid_data_r  <= in_data;
               skid_sop_r   <= in_startofpacket;
               skid_eop_r   <= in_endofpacket;
               in_ready     <= 1'b0;
            end else begin
               in_ready <= ~skid_valid_r;
            end
         end
         if (drop_inc_s && (drop_count != {CNT_W{1'b1}})) begin
            drop_count <= drop_count + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            drop_count <= drop_count;
         end
         if (err_set_s) begin
            protocol_err <= 1'b1;
         end else begin
            protocol_err <= protocol_err;
         end
      end
   end

endmodule

// File: tb/tb_ik_swift_hps_master_0_b2p_adapter.sv
// Directed testbench for ik_swift_hps_master_0_b2p_adapter with a captured-output scoreboard.
module tb_ik_swift_hps_master_0_b2p_adapter;

`ifdef B2P_CHANNEL_FILTER_EN
   localparam bit FILTER = 1'b1;
`else
   localparam bit FILTER = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        in_ready;
   logic        in_valid;
   logic [7:0]  in_data;
   logic [7:0]  in_channel;
   logic        in_startofpacket;
   logic        in_endofpacket;
   logic        out_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_startofpacket;
   logic        out_endofpacket;
   logic [15:0] drop_count;
   logic        protocol_err;

   int          n_vec = 0;
   int          n_err = 0;
   int          exp_drop = 0;
   logic [9:0]  got_q[$];
   logic [9:0]  exp_q[$];

   ik_swift_hps_master_0_b2p_adapter dut (
      .clk(clk), .reset(reset), .in_ready(in_ready), .in_valid(in_valid),
      .in_data(in_data), .in_channel(in_channel), .in_startofpacket(in_startofpacket),
      .in_endofpacket(in_endofpacket), .out_ready(out_ready), .out_valid(out_valid),
      .out_data(out_data), .out_startofpacket(out_startofpacket),
      .out_endofpacket(out_endofpacket), .drop_count(drop_count), .protocol_err(protocol_err)
   );

   always #5 clk = ~clk;

   // Capture every source transfer (sampled mid-cycle, committed at the next rising edge).
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready)
         got_q.push_back({out_startofpacket, out_endofpacket, out_data});
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic beat(input logic sop, input logic eop, input logic [7:0] ch, input logic [7:0] d);
      logic ok;
      int   n;
      in_valid = 1'b1; in_startofpacket = sop; in_endofpacket = eop;
      in_channel = ch; in_data = d;
      ok = 1'b0; n = 0;
      while (!ok && n < 100) begin
         @(negedge clk); ok = in_ready;
         @(posedge clk); #1; n++;
      end
      if (!ok) check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic expect_beat(input logic sop, input logic eop, input logic [7:0] d);
      exp_q.push_back({sop, eop, d});
   endtask

   task automatic drain_and_compare(input string name);
      out_ready = 1'b1;
      repeat (6) begin @(posedge clk); #1; end
      check({name, "_len"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         check($sformatf("%s_beat%0d", name, i), {22'd0, got_q[i]}, {22'd0, exp_q[i]});
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_data = 8'd0; in_channel = 8'd0;
      in_startofpacket = 1'b0; in_endofpacket = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      do_reset();
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_drop_count", drop_count, 0);
      check("rst_protocol_err", protocol_err, 0);

      // Pass packet, including 1-cycle latency on the first beat.
      beat(1'b1, 1'b0, 8'd0, 8'h11);
      check("pass_lat_valid", out_valid, 1);
      check("pass_lat_data", out_data, 8'h11);
      check("pass_lat_sop", out_startofpacket, 1);
      beat(1'b0, 1'b0, 8'd0, 8'h22);
      beat(1'b0, 1'b0, 8'd0, 8'h33);
      beat(1'b0, 1'b1, 8'd0, 8'h44);
      expect_beat(1, 0, 8'h11); expect_beat(0, 0, 8'h22);
      expect_beat(0, 0, 8'h33); expect_beat(0, 1, 8'h44);
      drain_and_compare("pass");
      check("pass_drops", drop_count, 0);

      // Drop a ch=5 packet, then pass a ch=0 packet.
      beat(1'b1, 1'b0, 8'd5, 8'h51); check("drop_rdy0", in_ready, 1);
      beat(1'b0, 1'b0, 8'd5, 8'h52); check("drop_rdy1", in_ready, 1);
      beat(1'b0, 1'b1, 8'd5, 8'h53); check("drop_rdy2", in_ready, 1);
      beat(1'b1, 1'b0, 8'd0, 8'h61);
      beat(1'b0, 1'b1, 8'd0, 8'h62);
      if (FILTER) exp_drop++;
      else begin expect_beat(1, 0, 8'h51); expect_beat(0, 0, 8'h52); expect_beat(0, 1, 8'h53); end
      expect_beat(1, 0, 8'h61); expect_beat(0, 1, 8'h62);
      drain_and_compare("drop");
      check("drop_count1", drop_count, exp_drop);

      // Backpressure: out_ready follows 1,0,0,1 while an 8-beat packet streams in.
      fork
         begin
            for (int i = 0; i < 8; i++)
               beat(i == 0, i == 7, 8'd0, 8'(8'h80 + i));
         end
         begin
            for (int k = 0; k < 40; k++) begin
               out_ready = (k % 4 == 0) || (k % 4 == 3);
               @(posedge clk); #1;
            end
         end
      join
      for (int i = 0; i < 8; i++) expect_beat(i == 0, i == 7, 8'(8'h80 + i));
      drain_and_compare("bp");
      check("bp_ready_after", in_ready, 1);

      // Single-beat packets.
      beat(1'b1, 1'b1, 8'd0, 8'hA5);
      beat(1'b1, 1'b1, 8'd7, 8'h5A);
      expect_beat(1, 1, 8'hA5);
      if (FILTER) exp_drop++;
      else expect_beat(1, 1, 8'h5A);
      drain_and_compare("single");
      check("single_drops", drop_count, exp_drop);

      // Framing errors: orphan beat, then SOP in the middle of a forwarded packet.
      check("err_before", protocol_err, 0);
      beat(1'b0, 1'b0, 8'd0, 8'h77);
      check("orphan_err", protocol_err, 1);
      beat(1'b1, 1'b0, 8'd0, 8'hA1);
      beat(1'b0, 1'b0, 8'd0, 8'hA2);
      beat(1'b1, 1'b0, 8'd0, 8'hB1);
      beat(1'b0, 1'b1, 8'd0, 8'hB2);
      expect_beat(1, 0, 8'hA1); expect_beat(0, 0, 8'hA2);
      expect_beat(1, 0, 8'hB1); expect_beat(0, 1, 8'hB2);
      drain_and_compare("framing");

      // Reset after beat 2 of 4.
      beat(1'b1, 1'b0, 8'd0, 8'hD1);
      beat(1'b0, 1'b0, 8'd0, 8'hD2);
      reset = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_valid", out_valid, 0);
      check("rst_mid_drops", drop_count, 0);
      check("rst_mid_err", protocol_err, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      beat(1'b1, 1'b0, 8'd0, 8'hC1);
      beat(1'b0, 1'b1, 8'd0, 8'hC2);
      expect_beat(1, 0, 8'hD1);
      expect_beat(1, 0, 8'hC1); expect_beat(0, 1, 8'hC2);
      drain_and_compare("rst_mid");
      check("rst_mid_err_after", protocol_err, 0);
      exp_drop = 0;

      // ch=5 packet: forwarded when filtering is compiled out.
      beat(1'b1, 1'b0, 8'd5, 8'hE1);
      beat(1'b0, 1'b1, 8'd5, 8'hE2);
      if (FILTER) exp_drop++;
      else begin expect_beat(1, 0, 8'hE1); expect_beat(0, 1, 8'hE2); end
      drain_and_compare("ch5");
      check("ch5_drops", drop_count, exp_drop);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
